// File: rtl/cpu_pkg.sv
// Shared definitions for the controller, IR fetch and memory port arbiter.
// Holds the common address/data widths and the arbiter state encoding.
package cpu_pkg;

    localparam int CPU_AW = 8;
    localparam int CPU_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin pick: on a tie the port that did not win last time is chosen.
// Combinational, zero latency; no backpressure (grant is a pure function of req).
// Grant is one-hot, or zero when nothing is requesting.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between CPU fetch (port 0) and loader/debug (port 1).
// Latency: gnt/mem_en one cycle after the request edge, read rvalid MEM_LAT+2 cycles after it.
// Backpressure: requesters hold req until gnt; req is only sampled in IDLE, one access in flight.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW      = CPU_AW,
    parameter int DW      = CPU_DW,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    localparam int CW = $clog2(MEM_LAT + 1);

    state_t        state;
    logic          last_grant;
    logic          owner;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;

    rr_arb2 u_rr_arb2 (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // mem_we/addr/wdata double as the latched request; they hold until the next grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            mem_en    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        owner      <= grant[1];
                        last_grant <= grant[1];
                        m0_gnt     <= grant[0];
                        m1_gnt     <= grant[1];
                        mem_en     <= 1'b1;
                        mem_we     <= grant[1] ? m1_we    : m0_we;
                        mem_addr   <= grant[1] ? m1_addr  : m0_addr;
                        mem_wdata  <= grant[1] ? m1_wdata : m0_wdata;
                        busy       <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (mem_we) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt   <= CW'(MEM_LAT);
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (cnt == CW'(1)) begin
                        if (owner) begin
                            m1_rdata  <= mem_rdata;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= mem_rdata;
                            m0_rvalid <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 1, 2, 4) share stimulus,
// each with its own fixed-latency memory model; most checks target the MEM_LAT=2 instance.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       m0_req = 1'b0, m0_we = 1'b0;
    logic [7:0] m0_addr = '0, m0_wdata = '0;
    logic       m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0] m1_addr = '0, m1_wdata = '0;

    logic       m0_gnt [3];
    logic       m0_rvalid [3];
    logic [7:0] m0_rdata [3];
    logic       m1_gnt [3];
    logic       m1_rvalid [3];
    logic [7:0] m1_rdata [3];
    logic       mem_en [3];
    logic       mem_we [3];
    logic [7:0] mem_addr [3];
    logic [7:0] mem_wdata [3];
    logic [7:0] mem_rdata [3];
    logic       busy [3];

    int n_tests = 0;
    int n_fail  = 0;

    // results of the last run_access, per instance
    int         ng [3];
    int         nr [3];
    int         nb [3];
    logic [7:0] rd [3];
    int         og;
    logic       g_en, g_we;
    logic [7:0] g_addr, g_wdata;

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [7:0] mem [256];
        logic       pv [4];
        logic [7:0] pa [4];

        mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_gnt    (m0_gnt[g]),
            .m0_rvalid (m0_rvalid[g]),
            .m0_rdata  (m0_rdata[g]),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_gnt    (m1_gnt[g]),
            .m1_rvalid (m1_rvalid[g]),
            .m1_rdata  (m1_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );

        // read data is valid only in the cycle exactly LAT cycles after mem_en
        assign mem_rdata[g] = pv[LAT-1] ? mem[pa[LAT-1]] : 8'hEE;

        always @(posedge clk) begin
            if (!reset) begin
                for (int k = 0; k < 256; k++) mem[k] <= init_val(8'(k));
                for (int k = 0; k < 4; k++) begin
                    pv[k] <= 1'b0;
                    pa[k] <= '0;
                end
            end else begin
                if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
                pv[0] <= mem_en[g] && !mem_we[g];
                pa[0] <= mem_addr[g];
                for (int k = 1; k < 4; k++) begin
                    pv[k] <= pv[k-1];
                    pa[k] <= pa[k-1];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        m0_req = 1'b0;
        m1_req = 1'b0;
        reset  = 1'b0;
        tick;
        tick;
        reset  = 1'b1;
    endtask

    // Issue one access on port p, drop req at grant, run until every instance is idle again.
    task automatic run_access(input int p, input logic we, input logic [7:0] addr,
                              input logic [7:0] wdata);
        for (int i = 0; i < 3; i++) begin
            ng[i] = 0; nr[i] = 0; nb[i] = 0; rd[i] = '0;
        end
        og = 0; g_en = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
        if (p == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
        for (int n = 1; n <= 30; n++) begin
            tick;
            for (int i = 0; i < 3; i++) begin
                logic       gv, vv, ov;
                logic [7:0] dv;
                gv = (p == 0) ? m0_gnt[i]    : m1_gnt[i];
                vv = (p == 0) ? m0_rvalid[i] : m1_rvalid[i];
                dv = (p == 0) ? m0_rdata[i]  : m1_rdata[i];
                ov = (p == 0) ? (m1_gnt[i] | m1_rvalid[i]) : (m0_gnt[i] | m0_rvalid[i]);
                if (gv && ng[i] == 0) ng[i] = n;
                if (vv && nr[i] == 0) begin
                    nr[i] = n;
                    rd[i] = dv;
                end
                if (ng[i] != 0 && n > ng[i] && !busy[i] && nb[i] == 0) nb[i] = n;
                if (ov) og++;
            end
            if (ng[1] == n) begin
                g_en = mem_en[1]; g_we = mem_we[1]; g_addr = mem_addr[1]; g_wdata = mem_wdata[1];
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            if (nb[0] != 0 && nb[1] != 0 && nb[2] != 0) break;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ev;
        int         k;
        int         both;
        int         seq [4];
        int         m0v;
        logic [7:0] m0d;

        // reset state
        tick;
        chk("rst_busy",     32'(busy[1]),     0);
        chk("rst_mem_en",   32'(mem_en[1]),   0);
        chk("rst_mem_we",   32'(mem_we[1]),   0);
        chk("rst_mem_addr", 32'(mem_addr[1]), 0);
        chk("rst_gnt",      32'({m0_gnt[1], m1_gnt[1]}), 0);
        chk("rst_rdata",    32'({m0_rdata[1], m1_rdata[1]}), 0);
        reset = 1'b1;
        tick;

        // single read, port 0
        run_access(0, 1'b0, 8'h10, 8'h00);
        chk("rd_gnt_cyc",    32'(ng[1]),   1);
        chk("rd_mem_en",     32'(g_en),    1);
        chk("rd_mem_we",     32'(g_we),    0);
        chk("rd_mem_addr",   32'(g_addr),  32'h10);
        chk("rd_rvalid_cyc", 32'(nr[1]),   4);
        chk("rd_rdata",      32'(rd[1]),   32'hA5);
        chk("rd_busy_clr",   32'(nb[1]),   5);
        chk("rd_other_port", 32'(og),      0);

        // single write, port 1, then read it back
        run_access(1, 1'b1, 8'h20, 8'h3C);
        chk("wr_gnt_cyc",    32'(ng[1]),   1);
        chk("wr_mem_en",     32'(g_en),    1);
        chk("wr_mem_we",     32'(g_we),    1);
        chk("wr_mem_addr",   32'(g_addr),  32'h20);
        chk("wr_mem_wdata",  32'(g_wdata), 32'h3C);
        chk("wr_no_rvalid",  32'(nr[1]),   0);
        chk("wr_busy_clr",   32'(nb[1]),   2);
        chk("wr_other_port", 32'(og),      0);
        run_access(1, 1'b0, 8'h20, 8'h00);
        chk("wr_readback",   32'(rd[1]),   32'h3C);
        chk("m0_rdata_kept", 32'(m0_rdata[1]), 32'hA5);

        // reset during the WAIT phase of a read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        tick;
        m0_req = 1'b0;
        chk("ar_gnt", 32'(m0_gnt[1]), 1);
        tick;
        #2 reset = 1'b0;
        #1;
        chk("ar_mem_en", 32'(mem_en[1]),   0);
        chk("ar_busy",   32'(busy[1]),     0);
        chk("ar_rdata",  32'(m0_rdata[1]), 0);
        tick;
        reset = 1'b1;
        ev = 0;
        for (int n = 0; n < 8; n++) begin
            tick;
            if (m0_rvalid[1] || m1_rvalid[1] || m0_gnt[1] || m1_gnt[1] || mem_en[1] || busy[1])
                ev++;
        end
        chk("ar_quiet", 32'(ev), 0);

        // both ports requesting continuously after reset
        do_reset;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h30; m1_wdata = 8'h77;
        k = 0; both = 0;
        for (int n = 0; n < 60 && k < 4; n++) begin
            tick;
            if (m0_gnt[1] && m1_gnt[1]) both++;
            if (m0_gnt[1]) begin seq[k] = 0; k++; end
            else if (m1_gnt[1]) begin seq[k] = 1; k++; end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("rr_count", 32'(k), 4);
        if (k == 4) begin
            chk("rr_grant0", 32'(seq[0]), 0);
            chk("rr_grant1", 32'(seq[1]), 1);
            chk("rr_grant2", 32'(seq[2]), 0);
            chk("rr_grant3", 32'(seq[3]), 1);
        end
        chk("rr_both", 32'(both), 0);
        chk("rr_m1_rdata_kept", 32'(m1_rdata[1]), 0);

        // port 1 request withdrawn before the arbiter returns to IDLE
        do_reset;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h11;
        tick;
        m0_req = 1'b0;
        tick;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h40;
        tick;
        m1_req = 1'b0;
        ev = 0; m0v = 0; m0d = '0;
        for (int n = 0; n < 12; n++) begin
            tick;
            if (m1_gnt[1] || m1_rvalid[1]) ev++;
            if (m0_rvalid[1]) begin m0v++; m0d = m0_rdata[1]; end
        end
        chk("wd_m1_never", 32'(ev),  0);
        chk("wd_m0_resp",  32'(m0v), 1);
        chk("wd_m0_data",  32'(m0d), 32'h4B);

        // latency across MEM_LAT = 1, 2, 4
        do_reset;
        run_access(0, 1'b0, 8'h10, 8'h00);
        chk("lat1_rvalid_cyc", 32'(nr[0]), 3);
        chk("lat1_rdata",      32'(rd[0]), 32'hA5);
        chk("lat2_rvalid_cyc", 32'(nr[1]), 4);
        chk("lat4_rvalid_cyc", 32'(nr[2]), 6);
        chk("lat4_rdata",      32'(rd[2]), 32'hA5);
        chk("lat4_busy_clr",   32'(nb[2]), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
